// File: rtl/hello_scroll_ctrl.sv
// rtl/hello_scroll_ctrl.sv - HELLO message rotator driving five character codes and the code-mux select
module hello_scroll_ctrl #(
    parameter int          TICK_DIV = 50000000,
    parameter logic [14:0] MSG      = 15'b011_010_010_001_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       dir,
    input  logic       step,
    input  logic       clr,
    output logic [2:0] sel,
    output logic [2:0] d0,
    output logic [2:0] d1,
    output logic [2:0] d2,
    output logic [2:0] d3,
    output logic [2:0] d4,
    output logic       scrolling,
    output logic       wrap
);

    localparam int             CW      = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0]  CNT_MAX = CW'(TICK_DIV - 1);

    typedef enum logic [1:0] {IDLE, SCROLL, HOLD} state_t;

    state_t        state, nxt_state;
    logic [2:0]    offset, cur_off, adv_off, nxt_off;
    logic [CW-1:0] cnt, nxt_cnt;
    logic          tick, adv, nxt_wrap;

    function automatic logic [2:0] code_at(input logic [2:0] off, input int i);
        int k;
        k = int'(off) + i;
        if (k >= 5) k = k - 5;
        return MSG[k*3 +: 3];
    endfunction

    always_comb begin
        // An out-of-range offset is treated as 0 so the next update repairs it
        cur_off   = (offset > 3'd4) ? 3'd0 : offset;
        tick      = (state == SCROLL) && (cnt == CNT_MAX);
        adv_off   = dir ? ((cur_off == 3'd0) ? 3'd4 : cur_off - 3'd1)
                        : ((cur_off == 3'd4) ? 3'd0 : cur_off + 3'd1);
        adv       = 1'b0;
        nxt_state = state;
        nxt_cnt   = cnt;
        if (clr) begin
            nxt_state = IDLE;
            nxt_cnt   = '0;
        end else begin
            case (state)
                IDLE, HOLD: begin
                    if (run) begin
                        nxt_state = SCROLL;
                        nxt_cnt   = '0;
                    end else if (step) begin
                        adv = 1'b1;
                    end
                end
                SCROLL: begin
                    // A tick still shifts even when run drops on the same cycle
                    nxt_cnt = tick ? '0 : cnt + CW'(1);
                    adv     = tick;
                    if (!run) nxt_state = HOLD;
                end
                default: nxt_state = IDLE;
            endcase
        end
        nxt_off  = clr ? 3'd0 : (adv ? adv_off : cur_off);
        nxt_wrap = adv && (dir ? (cur_off == 3'd0) : (cur_off == 3'd4));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            offset    <= 3'd0;
            cnt       <= '0;
            sel       <= 3'd0;
            wrap      <= 1'b0;
            scrolling <= 1'b0;
            d0        <= MSG[2:0];
            d1        <= MSG[5:3];
            d2        <= MSG[8:6];
            d3        <= MSG[11:9];
            d4        <= MSG[14:12];
        end else begin
            state     <= nxt_state;
            offset    <= nxt_off;
            cnt       <= nxt_cnt;
            sel       <= nxt_off;
            wrap      <= nxt_wrap;
            scrolling <= (nxt_state == SCROLL);
            d0        <= code_at(nxt_off, 0);
            d1        <= code_at(nxt_off, 1);
            d2        <= code_at(nxt_off, 2);
            d3        <= code_at(nxt_off, 3);
            d4        <= code_at(nxt_off, 4);
        end
    end

endmodule

// File: tb/tb_hello_scroll_ctrl.sv
// tb/tb_hello_scroll_ctrl.sv - directed self-checking bench for hello_scroll_ctrl
module tb_hello_scroll_ctrl;

    logic       clk = 1'b0;
    logic       rst, run, dir, step, clr;
    logic [2:0] sel, d0, d1, d2, d3, d4;
    logic       scrolling, wrap;
    logic [14:0] dv;

    int total = 0;
    int bad   = 0;

    // {d4,d3,d2,d1,d0} for each offset
    localparam logic [14:0] OFF0 = 15'b011_010_010_001_000;
    localparam logic [14:0] OFF1 = 15'b000_011_010_010_001;
    localparam logic [14:0] OFF2 = 15'b001_000_011_010_010;
    localparam logic [14:0] OFF3 = 15'b010_001_000_011_010;
    localparam logic [14:0] OFF4 = 15'b010_010_001_000_011;

    hello_scroll_ctrl #(.TICK_DIV(4), .MSG(15'b011_010_010_001_000)) dut (
        .clk(clk), .rst(rst), .run(run), .dir(dir), .step(step), .clr(clr),
        .sel(sel), .d0(d0), .d1(d1), .d2(d2), .d3(d3), .d4(d4),
        .scrolling(scrolling), .wrap(wrap)
    );

    always #5 clk = ~clk;
    assign dv = {d4, d3, d2, d1, d0};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; dir = 1'b0; step = 1'b0; clr = 1'b0;
        cyc(2);
        chk("rst_sel", sel, 0);
        chk("rst_d", dv, OFF0);
        chk("rst_scr", scrolling, 0);
        chk("rst_wrap", wrap, 0);
        rst = 1'b0;

        // Auto-scroll left
        run = 1'b1; dir = 1'b0;
        cyc(1);
        chk("l_scr", scrolling, 1);
        cyc(3);
        chk("l_sel0", sel, 0);
        cyc(1);
        chk("l_sel1", sel, 1);
        chk("l_d1", dv, OFF1);
        for (int k = 2; k <= 4; k++) begin
            cyc(4);
            chk("l_selk", sel, k);
            chk("l_nowrap", wrap, 0);
        end
        cyc(4);
        chk("l_wrapsel", sel, 0);
        chk("l_wrap", wrap, 1);
        chk("l_wrapd", dv, OFF0);
        cyc(1);
        chk("l_wrapoff", wrap, 0);
        cyc(3);
        chk("l_again", sel, 1);

        // Asynchronous reset mid-scroll
        #2 rst = 1'b1;
        #1;
        chk("arst_sel", sel, 0);
        chk("arst_d", dv, OFF0);
        chk("arst_scr", scrolling, 0);

        // Right scroll from reset
        run = 1'b1; dir = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        cyc(4);
        chk("r_sel0", sel, 0);
        chk("r_scr", scrolling, 1);
        cyc(1);
        chk("r_sel4", sel, 4);
        chk("r_d4", dv, OFF4);
        chk("r_wrap", wrap, 1);
        cyc(1);
        chk("r_wrapoff", wrap, 0);
        cyc(3);
        chk("r_sel3", sel, 3);
        chk("r_d3", dv, OFF3);

        // clr on a tick cycle
        cyc(3);
        clr = 1'b1;
        cyc(1);
        clr = 1'b0; run = 1'b0;
        chk("clr_sel", sel, 0);
        chk("clr_scr", scrolling, 0);
        chk("clr_wrap", wrap, 0);
        chk("clr_d", dv, OFF0);
        cyc(2);
        chk("clr_idle", sel, 0);

        // Step in IDLE, both directions across the wrap point
        dir = 1'b1; step = 1'b1;
        cyc(1);
        step = 1'b0;
        chk("is_sel4", sel, 4);
        chk("is_wrap", wrap, 1);
        chk("is_scr", scrolling, 0);
        cyc(1);
        chk("is_wrapoff", wrap, 0);
        dir = 1'b0; step = 1'b1;
        cyc(1);
        step = 1'b0;
        chk("is_sel0", sel, 0);
        chk("is_wrapl", wrap, 1);

        // Hold and step
        run = 1'b1;
        cyc(9);
        chk("h_sel2", sel, 2);
        chk("h_d2", dv, OFF2);
        run = 1'b0;
        cyc(21);
        chk("h_hold", sel, 2);
        chk("h_scr", scrolling, 0);
        step = 1'b1;
        cyc(1);
        step = 1'b0;
        chk("h_step", sel, 3);
        run = 1'b1;
        cyc(4);
        chk("h_resume3", sel, 3);
        cyc(1);
        chk("h_resume4", sel, 4);

        // run falls on a tick: one final shift, then HOLD
        cyc(3);
        run = 1'b0;
        cyc(1);
        chk("rf_sel", sel, 0);
        chk("rf_wrap", wrap, 1);
        chk("rf_scr", scrolling, 0);
        cyc(8);
        chk("rf_hold", sel, 0);

        // step ignored while scrolling, dir change mid-scroll
        run = 1'b1;
        cyc(2);
        step = 1'b1;
        cyc(1);
        step = 1'b0;
        chk("ss_ign", sel, 0);
        cyc(1);
        chk("ss_ign2", sel, 0);
        cyc(1);
        chk("ss_tick", sel, 1);
        dir = 1'b1;
        cyc(4);
        chk("dc_sel0", sel, 0);
        chk("dc_nowrap", wrap, 0);
        cyc(4);
        chk("dc_sel4", sel, 4);
        chk("dc_wrap", wrap, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
